// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bundle: PC/instruction in, redirect/stall controls, next-PC and IF/ID register out.
// Optional fetch/bubble counters are present only when IF_STATS_EN is defined.
interface if_id_stage_if #(
    parameter int WIDTH       = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [WIDTH-1:0]       PcIn;
    logic [INSTR_WIDTH-1:0] Instr;
    logic                   stall;
    logic                   branch_taken;
    logic [WIDTH-1:0]       branch_target;
    logic                   jump;
    logic [WIDTH-1:0]       jump_target;
    logic [WIDTH-1:0]       PcNext;
    logic [WIDTH-1:0]       IfIdPc;
    logic [INSTR_WIDTH-1:0] IfIdInstr;
    logic                   IfIdValid;
`ifdef IF_STATS_EN
    logic [31:0]            fetch_count;
    logic [31:0]            bubble_count;

    modport master (
        output PcIn, Instr, stall, branch_taken, branch_target, jump, jump_target,
        input  PcNext, IfIdPc, IfIdInstr, IfIdValid, fetch_count, bubble_count
    );
    modport slave (
        input  PcIn, Instr, stall, branch_taken, branch_target, jump, jump_target,
        output PcNext, IfIdPc, IfIdInstr, IfIdValid, fetch_count, bubble_count
    );
`else
    modport master (
        output PcIn, Instr, stall, branch_taken, branch_target, jump, jump_target,
        input  PcNext, IfIdPc, IfIdInstr, IfIdValid
    );
    modport slave (
        input  PcIn, Instr, stall, branch_taken, branch_target, jump, jump_target,
        output PcNext, IfIdPc, IfIdInstr, IfIdValid
    );
`endif
endinterface

// File: rtl/if_id_stage.sv
// Purpose: next-PC select plus IF/ID pipeline register with stall hold and redirect bubbles (IF_STATS_EN adds counters).
// Latency: PcNext combinational; instruction at cycle N appears on IfId* after edge N+1.
// Backpressure: stall holds PC and IF/ID contents; a jump/branch redirect overrides stall and injects FLUSH_SLOTS bubbles.
module if_id_stage #(
    parameter int WIDTH       = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int FLUSH_SLOTS = 1
) (
    input logic          clk,
    input logic          rst,
    if_id_stage_if.slave bus
);
    typedef enum logic {RUN, SQUASH} state_t;

    localparam logic [1:0] RELOAD = 2'(FLUSH_SLOTS - 1);
    localparam bit         MULTI  = (FLUSH_SLOTS > 1);

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]       pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   vld_q, vld_d;
    logic                   redirect;
    logic                   load_bubble;
    logic                   load_fetch;
    logic [WIDTH-1:0]       pc_inc;

    assign redirect = bus.jump | bus.branch_taken;
    assign pc_inc   = bus.PcIn + WIDTH'(1);

    always_comb begin
        if (bus.jump)
            bus.PcNext = bus.jump_target;
        else if (bus.branch_taken)
            bus.PcNext = bus.branch_target;
        else if (bus.stall)
            bus.PcNext = bus.PcIn;
        else
            bus.PcNext = pc_inc;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_bubble = 1'b0;
        load_fetch  = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    load_bubble = 1'b1;
                    if (MULTI) begin
                        cnt_d   = RELOAD;
                        state_d = SQUASH;
                    end
                end else if (!bus.stall) begin
                    load_fetch = 1'b1;
                end
            end
            SQUASH: begin
                if (redirect) begin
                    load_bubble = 1'b1;
                    if (MULTI)
                        cnt_d = RELOAD;
                    else
                        state_d = RUN;
                end else if (!bus.stall) begin
                    // cnt counts bubbles still owed; the one loaded at cnt==1 is the last
                    load_bubble = 1'b1;
                    cnt_d       = cnt_q - 2'd1;
                    if (cnt_q == 2'd1)
                        state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        if (load_bubble) begin
            pc_d    = '0;
            instr_d = '0;
            vld_d   = 1'b0;
        end else if (load_fetch) begin
            pc_d    = pc_inc;
            instr_d = bus.Instr;
            vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            pc_q    <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.IfIdPc    = pc_q;
    assign bus.IfIdInstr = instr_q;
    assign bus.IfIdValid = vld_q;

`ifdef IF_STATS_EN
    logic [31:0] fetch_q, bubble_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_q  <= 32'd0;
            bubble_q <= 32'd0;
        end else begin
            if (load_fetch && fetch_q != 32'hFFFF_FFFF)
                fetch_q <= fetch_q + 32'd1;
            if (load_bubble && bubble_q != 32'hFFFF_FFFF)
                bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bus.fetch_count  = fetch_q;
    assign bus.bubble_count = bubble_q;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: two instances (one and two flush slots) share stimulus and are checked each cycle
// against a bubbles-owed model, plus hand-computed checks of reset, stall, redirect and wrap cases.
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, instr, br_tgt, jp_tgt;
    logic        stall, br, jp;
    bit          done = 1'b0;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    if_id_stage_if #(.WIDTH(32), .INSTR_WIDTH(32)) bus_a ();
    if_id_stage_if #(.WIDTH(32), .INSTR_WIDTH(32)) bus_b ();

    assign bus_a.PcIn = pc_in;          assign bus_b.PcIn = pc_in;
    assign bus_a.Instr = instr;         assign bus_b.Instr = instr;
    assign bus_a.stall = stall;         assign bus_b.stall = stall;
    assign bus_a.branch_taken = br;     assign bus_b.branch_taken = br;
    assign bus_a.branch_target = br_tgt; assign bus_b.branch_target = br_tgt;
    assign bus_a.jump = jp;             assign bus_b.jump = jp;
    assign bus_a.jump_target = jp_tgt;  assign bus_b.jump_target = jp_tgt;

    if_id_stage #(.WIDTH(32), .INSTR_WIDTH(32), .FLUSH_SLOTS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    if_id_stage #(.WIDTH(32), .INSTR_WIDTH(32), .FLUSH_SLOTS(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instance owes some number of bubbles after a redirect; one is paid per unstalled cycle.
    int          fs [2] = '{1, 2};
    int          owed [2];
    logic [31:0] m_pc [2], m_ins [2], m_fc [2], m_bc [2];
    logic        m_vld [2];

    function automatic logic [31:0] exp_next();
        if (jp) return jp_tgt;
        if (br) return br_tgt;
        if (stall) return pc_in;
        return pc_in + 32'd1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                owed[k] = 0; m_pc[k] = 0; m_ins[k] = 0; m_vld[k] = 0; m_fc[k] = 0; m_bc[k] = 0;
            end else if (jp || br || (!stall && owed[k] > 0)) begin
                owed[k] = (jp || br) ? fs[k] - 1 : owed[k] - 1;
                m_pc[k] = 0; m_ins[k] = 0; m_vld[k] = 0;
                if (m_bc[k] != 32'hFFFF_FFFF) m_bc[k] = m_bc[k] + 1;
            end else if (!stall) begin
                m_pc[k] = pc_in + 32'd1; m_ins[k] = instr; m_vld[k] = 1;
                if (m_fc[k] != 32'hFFFF_FFFF) m_fc[k] = m_fc[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("next_a", bus_a.PcNext, exp_next());
            check("pc_a", bus_a.IfIdPc, m_pc[0]);
            check("instr_a", bus_a.IfIdInstr, m_ins[0]);
            check("valid_a", 32'(bus_a.IfIdValid), 32'(m_vld[0]));
            check("next_b", bus_b.PcNext, exp_next());
            check("pc_b", bus_b.IfIdPc, m_pc[1]);
            check("instr_b", bus_b.IfIdInstr, m_ins[1]);
            check("valid_b", 32'(bus_b.IfIdValid), 32'(m_vld[1]));
`ifdef IF_STATS_EN
            check("fetch_a", bus_a.fetch_count, m_fc[0]);
            check("bubble_a", bus_a.bubble_count, m_bc[0]);
            check("fetch_b", bus_b.fetch_count, m_fc[1]);
            check("bubble_b", bus_b.bubble_count, m_bc[1]);
`endif
        end
    end

    task automatic drv(input logic [31:0] p, input logic [31:0] i, input logic s,
                       input logic b, input logic [31:0] bt, input logic j, input logic [31:0] jt);
        pc_in = p; instr = i; stall = s; br = b; br_tgt = bt; jp = j; jp_tgt = jt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        check("rst_valid_a", 32'(bus_a.IfIdValid), 0);
        check("rst_pc_b", bus_b.IfIdPc, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(32'(100 + i), 32'h1000_0000 + 32'(i), 0, 0, 0, 0, 0);
            tick();
        end
        check("lat_pc_a", bus_a.IfIdPc, 32'd104);
        check("lat_instr_b", bus_b.IfIdInstr, 32'h1000_0003);

        // Reset mid-run must clear outputs before any edge
        rst = 1'b1;
        #1;
        check("arst_valid_a", 32'(bus_a.IfIdValid), 0);
        check("arst_pc_a", bus_a.IfIdPc, 0);
        check("arst_instr_b", bus_b.IfIdInstr, 0);
        tick();
        rst = 1'b0;
        drv(0, 32'h2008_0005, 0, 0, 0, 0, 0);
        tick();
        check("first_pc_a", bus_a.IfIdPc, 32'd1);
        check("first_instr_a", bus_a.IfIdInstr, 32'h2008_0005);
        check("first_valid_b", 32'(bus_b.IfIdValid), 1);

        // Stall holds everything
        drv(5, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_next", bus_a.PcNext, 32'd5);
            tick();
            check("stall_hold_pc", bus_a.IfIdPc, 32'd1);
            check("stall_hold_instr", bus_b.IfIdInstr, 32'h2008_0005);
        end
        drv(5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        #1 check("unstall_next", bus_a.PcNext, 32'd6);
        tick();
        check("unstall_pc", bus_b.IfIdPc, 32'd6);

        // Branch: one bubble on a, two on b
        drv(8, 32'h1111_1111, 0, 1, 20, 0, 0);
        #1 check("br_next_b", bus_b.PcNext, 32'd20);
        tick();
        check("br_valid_a", 32'(bus_a.IfIdValid), 0);
        check("br_instr_b", bus_b.IfIdInstr, 0);
        drv(20, 32'h2222_2222, 0, 0, 0, 0, 0);
        tick();
        check("br_resume_a", bus_a.IfIdPc, 32'd21);
        check("br_slot2_b", 32'(bus_b.IfIdValid), 0);
        drv(21, 32'h3333_3333, 0, 0, 0, 0, 0);
        tick();
        check("br_resume_valid_b", 32'(bus_b.IfIdValid), 1);
        check("br_resume_pc_b", bus_b.IfIdPc, 32'd22);

        // Jump beats branch, and redirect beats stall
        drv(22, 32'h4444_4444, 1, 1, 20, 1, 40);
        #1 check("jmp_next", bus_a.PcNext, 32'd40);
        tick();
        check("jmp_bubble_a", 32'(bus_a.IfIdValid), 0);
        check("jmp_bubble_instr_a", bus_a.IfIdInstr, 0);

        // PC wrap
        drv(32'hFFFF_FFFF, 32'h5555_5555, 0, 0, 0, 0, 0);
        #1 check("wrap_next", bus_a.PcNext, 32'd0);
        tick();
        check("wrap_pc_a", bus_a.IfIdPc, 32'd0);
        check("wrap_valid_a", 32'(bus_a.IfIdValid), 1);

        // Stall freezes a squash in progress
        drv(50, 32'h6666_6666, 0, 1, 60, 0, 0); tick();
        drv(60, 32'h7777_7777, 1, 0, 0, 0, 0); tick(); tick();
        drv(60, 32'h7777_7777, 0, 0, 0, 0, 0); tick();
        check("sq_stall_b", 32'(bus_b.IfIdValid), 0);
        drv(61, 32'h8888_8888, 0, 0, 0, 0, 0); tick();
        check("sq_stall_resume_b", bus_b.IfIdPc, 32'd62);

        // Redirect during squash restarts the count
        drv(62, 32'h9999_9999, 0, 0, 0, 1, 70); tick();
        drv(70, 32'h9999_9999, 0, 1, 90, 0, 0); tick();
        drv(90, 32'hAAAA_AAAA, 0, 0, 0, 0, 0); tick();
        check("sq_reload_b", 32'(bus_b.IfIdValid), 0);
        drv(91, 32'hBBBB_BBBB, 0, 0, 0, 0, 0); tick();
        check("sq_reload_resume_b", bus_b.IfIdPc, 32'd92);

        for (int i = 0; i < 40; i++) begin
            drv(32'(200 + i), 32'hA000_0000 + 32'(i), (i % 5) == 2, (i % 7) == 3, 32'(300 + i),
                (i % 11) == 6, 32'(400 + i));
            tick();
        end

`ifdef IF_STATS_EN
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drv(32'(i), 32'hC000_0000 + 32'(i), (i == 6 || i == 7), (i == 5), 32'd500, 0, 0);
            tick();
        end
        check("stat_fetch_a", bus_a.fetch_count, 32'd10);
        check("stat_bubble_a", bus_a.bubble_count, 32'd1);
        check("stat_fetch_b", bus_b.fetch_count, 32'd9);
        check("stat_bubble_b", bus_b.bubble_count, 32'd2);
`endif

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
